mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch unit and the load/store unit.
- Needed by the planned multi-cycle/pipelined CPU, where fetch and data accesses can no longer use separate ports in the same cycle.
- Sits between the CPU core and the memory model. The memory has synchronous write and one-cycle-latency read.
- Round-robin arbitration. Each requester has a req/ack handshake. Read data is forwarded to the owning requester.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width from requesters.
- MEM_AW, 12, memory word-address width. mem_addr = addr[MEM_AW+1:2].

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch byte address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch access complete.
- if_rdata  out  DATA_W  fetched word; valid only while if_ack=1.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load; stable while d_req is high.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; data access complete.
- d_rdata  out  DATA_W  load data; valid only while d_ack=1 and access was a load.
- mem_en  out  1  memory access strobe for this cycle.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  MEM_AW  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read issue.

Behaviour:
- State: resp_valid (1b), resp_owner (IF/D), resp_is_rd (1b), last_grant (IF/D).
- Reset values: resp_valid=0, last_grant=IF.
- Reset state of outputs: if_ack=d_ack=0, mem_en=mem_we=0, rdata outputs=0.
- Issue cycle (combinational from current state and inputs):
  - eligible_IF = if_req & ~(resp_valid & resp_owner==IF).
  - eligible_D = d_req & ~(resp_valid & resp_owner==D).
  - A requester being acked this cycle is never re-granted in the same cycle.
- Arbitration:
  - Only one eligible: it wins.
  - Both eligible: the one not equal to last_grant wins. From reset (last_grant=IF), D wins the first contention.
- Winner drives the memory:
  - mem_en=1.
  - mem_addr = winner addr[MEM_AW+1:2]; upper address bits ignored (wrap). addr[1:0] ignored.
  - mem_we = winner is D & d_we.
  - mem_wdata = d_wdata.
  - No winner: mem_en=0, mem_we=0, other mem outputs don't-care (drive 0).
- On the rising edge with a winner:
  - resp_valid<=1, resp_owner<=winner, resp_is_rd<=~mem_we, last_grant<=winner.
  - With no winner: resp_valid<=0.
- Response cycle (resp_valid=1):
  - Owner's ack=1.
  - If resp_is_rd, owner's rdata = mem_rdata (combinational pass-through). Otherwise rdata=0.
  - Non-owner ack=0.
- Latency: grant to ack is exactly 1 cycle for both loads and stores.
  - With no contention, a lone requester re-asserting gets 1 access per 2 cycles.
  - With both requesting, accesses alternate IF/D every cycle (full memory throughput).
- Requester protocol:
  - Drop or re-present req on the cycle after ack.
  - req high in the ack cycle is ignored by the eligibility rule.
  - Withdrawing req before ack is illegal. An assertion in the bench flags it.
- Asynchronous reset mid-access: in-flight response is dropped, no ack is produced, state returns to reset values immediately. Requesters re-issue after reset.
- Simultaneous store by D and fetch by IF to the same word: the winner order decides visibility. A fetch after the store's ack sees the new value.

Decomposition:
- Shared package (mem_arb_pkg):
  - Owner encoding OWN_IF=0, OWN_D=1.
  - Default widths DATA_W/ADDR_W/MEM_AW.
- One sub-module, rr_pick2: 2-input round-robin picker.
  - Inputs: eligible[1:0], last.
  - Outputs: grant valid, grant id.
- All remaining logic lives in mem_port_arbiter.

Test Plan:
1. Reset, then if_req=1, if_addr=0x00000008, memory word 2=0x20080005:
   - Cycle 0: mem_en=1, mem_addr=2, mem_we=0.
   - Cycle 1: if_ack=1, if_rdata=0x20080005.
   - Cycle 2 (if_req held): re-issue.
2. Store then load, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF:
   - d_ack on the next cycle.
   - Then d_we=0 on the same address returns d_rdata=0xDEADBEEF.
   - if_ack stays 0 throughout.
3. Both requesting from reset:
   - Grant order is D, IF, D, IF on consecutive cycles.
   - Acks alternate d_ack, if_ack each cycle.
   - mem_en is high every cycle.
4. IF alone held high for 6 cycles:
   - mem_en pattern 1,0,1,0,1,0.
   - if_ack pattern 0,1,0,1,0,1.
5. Assert reset in the cycle after a D load grant:
   - No d_ack.
   - mem_en=0 immediately.
   - After release, re-issued load completes normally with correct data.
6. Address wrap, MEM_AW=12:
   - d_addr=0x00004004 hits word 1, the same as 0x00000004.
   - Data written via one address is read back via the other.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: owner encoding and
// default widths used by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned MEM_AW_DEF = 12;

  // Which requester owns a grant / response.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // The requester that is not 'o'.
  function automatic owner_e other_owner(input owner_e o);
    owner_e r;
    if (o == OWN_IF) begin
      r = OWN_D;
    end else begin
      r = OWN_IF;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker. Bit 0 of eligible_i is the fetch unit,
// bit 1 the load/store unit. On contention the requester that did not
// receive the previous grant wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] eligible_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Select the winner from the eligibility vector and the previous grant.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = OWN_IF;
    case (eligible_i)
      2'b01: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = OWN_IF;
      end
      2'b10: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = OWN_D;
      end
      2'b11: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = other_owner(owner_e'(last_i));
      end
      default: begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = OWN_IF;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory (sync write, 1-cycle read latency) between
// the instruction-fetch unit and the load/store unit. A grant drives the
// memory in the issue cycle; the owner is acked exactly one cycle later,
// with read data passed straight through from the memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MEM_AW = MEM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   resp_valid_q, resp_valid_d;
  owner_e resp_owner_q, resp_owner_d;
  logic   resp_is_rd_q, resp_is_rd_d;
  owner_e last_grant_q, last_grant_d;

  logic [1:0] eligible_s;
  logic       gnt_valid_s;
  logic       gnt_id_s;
  logic       if_resp_s;
  logic       d_resp_s;

  // Byte-offset and wrapped upper address bits are deliberately ignored.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                                d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

  // A requester being acked this cycle may not be re-granted; nothing is
  // granted while reset is asserted.
  always_comb begin
    if_resp_s     = resp_valid_q & (resp_owner_q == OWN_IF);
    d_resp_s      = resp_valid_q & (resp_owner_q == OWN_D);
    eligible_s[0] = if_req & ~if_resp_s & ~reset;
    eligible_s[1] = d_req & ~d_resp_s & ~reset;
  end

  rr_pick2 u_pick (
    .eligible_i  (eligible_s),
    .last_i      (last_grant_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  // Drive the memory from the winner and compute the next response state.
  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {MEM_AW{1'b0}};
    mem_wdata    = {DATA_W{1'b0}};
    resp_valid_d = 1'b0;
    resp_owner_d = resp_owner_q;
    resp_is_rd_d = resp_is_rd_q;
    last_grant_d = last_grant_q;
    if (gnt_valid_s) begin
      mem_en    = 1'b1;
      mem_wdata = d_wdata;
      if (gnt_id_s == OWN_D) begin
        mem_addr = d_addr[MEM_AW+1:2];
        mem_we   = d_we;
      end else begin
        mem_addr = if_addr[MEM_AW+1:2];
        mem_we   = 1'b0;
      end
      resp_valid_d = 1'b1;
      resp_owner_d = owner_e'(gnt_id_s);
      resp_is_rd_d = ~mem_we;
      last_grant_d = owner_e'(gnt_id_s);
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // Acks and read-data forwarding to the owner of the pending response.
  always_comb begin
    if_ack   = if_resp_s;
    d_ack    = d_resp_s;
    if_rdata = {DATA_W{1'b0}};
    d_rdata  = {DATA_W{1'b0}};
    if (if_resp_s && resp_is_rd_q) begin
      if_rdata = mem_rdata;
    end else begin
      if_rdata = {DATA_W{1'b0}};
    end
    if (d_resp_s && resp_is_rd_q) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = {DATA_W{1'b0}};
    end
  end

  // Response and round-robin state; reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_IF;
      resp_is_rd_q <= 1'b0;
      last_grant_q <= OWN_IF;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_is_rd_q <= resp_is_rd_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
